rep_pol_lfu: RTL and testbench
==============================

# rep_pol_lfu

Parametrised, sequential least-frequently-used replacement engine for an N-way set-associative cache. It keeps one saturating access counter per way per set, updates them on hit notifications, and answers victim queries with the lowest-count way of a set, lowest index winning ties. On counter saturation it runs an aging sweep that halves every counter, so old popularity decays. It sits beside the cache tag array and replaces the fixed 4-way, 32-bit combinational lowest-value selector.

## Interface
Parameters:
- WAYS, 4, associativity; power of two, >= 2
- SETS, 16, number of sets; power of two, >= 2
- CNT_W, 8, counter width in bits; >= 2
- Derived, not overridable: WAY_W = $clog2(WAYS), SET_W = $clog2(SETS), CNT_MAX = 2^CNT_W - 1

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  engine can accept a request
- req_op  in  1  0 = hit touch, 1 = victim query
- req_set  in  SET_W  target set
- req_way  in  WAY_W  hit way; ignored when req_op = 1
- rsp_valid  out  1  one-cycle pulse, victim result valid
- rsp_set  out  SET_W  set of the answered query
- rsp_way  out  WAY_W  chosen victim way
- age_busy  out  1  aging sweep in progress

## Operation
- Storage: cnt[s][w], CNT_W bits each, SETS*WAYS entries, held in flops.
- A request is accepted when req_valid && req_ready. req_ready = 1 only in IDLE. A requester holds valid and payload stable until accepted.
- Hit touch (op = 0): cnt[set][way] <= min(cnt + 1, CNT_MAX).
  - If the new value equals CNT_MAX (this includes touches at 254 -> 255, and touches to an already saturated counter), set age_pend.
- Victim query (op = 1):
  - Search all WAYS counters of req_set.
  - The minimum value wins. On a tie, the lowest way index wins.
  - Write cnt[set][victim] <= 1, because the newly filled line counts one access.
  - Register rsp_way and rsp_set, and pulse rsp_valid.
  - The search is combinational over the flop array as a balanced binary compare tree of depth WAY_W.
- There is no response backpressure. The consumer must sample on the rsp_valid pulse.
- FSM states: IDLE and AGE.
  - IDLE -> AGE on the edge after a hit that set age_pend. age_pend clears on entry to AGE.
  - AGE sweeps a set index from 0 to SETS-1, one set per cycle. Each cycle: cnt[idx][w] <= cnt[idx][w] >> 1 for all w.
  - AGE -> IDLE after set SETS-1 is processed.
- age_busy = 1 exactly while the state is AGE.
- Reset values: all cnt = 0, state IDLE, age_pend = 0, sweep idx = 0, rsp_valid = 0, rsp_way = 0, rsp_set = 0, age_busy = 0, req_ready = 1 once reset is released.
- Reset asserted mid-sweep aborts the sweep. All state returns to the reset values above, and no partial halving persists.
- Widths: increments saturate and never wrap. Halving is a logical shift right with zero fill.

## Timing
- Hit accepted in cycle T: the counter holds the new value from T+1.
- Query accepted in cycle T:
  - rsp_valid = 1 in T+1 with rsp_way/rsp_set (latency 1).
  - The victim counter reads 1 from T+1.
- Back-to-back requests are accepted every cycle in IDLE, at full throughput.
- A query in cycle T+1 to the same set sees the updates made in T, including its own earlier victim write.
- Saturating hit accepted in T:
  - AGE occupies T+1 .. T+SETS, and set s is halved in cycle T+1+s.
  - req_ready = 0 in T+1 .. T+SETS, and req_ready = 1 from T+SETS+1.
- A request pending during AGE stays pending and is accepted in T+SETS+1 against the halved counters.
- rsp_valid from a query accepted in T still pulses in T+1, even if AGE begins in T+1. The AGE trigger comes only from hits, so the two cannot be caused by the same request.

## Test plan
- Reset, then query set 3 -> rsp_valid=1 next cycle with rsp_way=0, rsp_set=3. Query set 3 again -> rsp_way=1, then 2, then 3. A fifth query -> rsp_way=0, since all counters are 1 and the tie goes to the lowest index.
- Set 5 touches: way0 x3, way1 x1, way2 x2, way3 x2. Query set 5 -> rsp_way=1, and cnt[5][1] reads 1 afterward.
- Tie: set 7 with way0=4, way1=3, way2=0, way3=0. Query -> rsp_way=2.
- Saturation (CNT_W=8, SETS=16): preload cnt[9][1]=5, then apply 255 hits to set 0 way 2.
  - On the 255th hit -> age_busy=1 and req_ready=0 for exactly 16 cycles.
  - Afterward cnt[0][2]=127 and cnt[9][1]=2.
  - A query held during the sweep is accepted on cycle 17 and answered on cycle 18.
- Reset mid-sweep: pull rst_n low during sweep cycle 8.
  - All outputs return to reset values immediately.
  - After release, req_ready=1, age_busy=0, and a query on any set -> rsp_way=0.
- Parameter sweep WAYS=8, SETS=4, CNT_W=4: set 2 counters {5,3,7,1,1,9,2,4} -> rsp_way=3. Then touch set 1 way 0 15 times -> AGE lasts 4 cycles.

Source files
------------

// File: rtl/rep_pol_lfu_if.sv
// Request/response bundle between a cache tag pipeline and the LFU replacement engine.
interface rep_pol_lfu_if #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 16
);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned SET_W = $clog2(SETS);

  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [SET_W-1:0] req_set;
  logic [WAY_W-1:0] req_way;
  logic             rsp_valid;
  logic [SET_W-1:0] rsp_set;
  logic [WAY_W-1:0] rsp_way;
  logic             age_busy;

  modport master (
    output req_valid, req_op, req_set, req_way,
    input  req_ready, rsp_valid, rsp_set, rsp_way, age_busy
  );

  modport slave (
    input  req_valid, req_op, req_set, req_way,
    output req_ready, rsp_valid, rsp_set, rsp_way, age_busy
  );
endinterface

// File: rtl/rep_pol_lfu.sv
// LFU replacement engine: saturating per-way access counters, lowest-count victim
// selection, and a one-set-per-cycle halving sweep triggered by counter saturation.
module rep_pol_lfu #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  rep_pol_lfu_if.slave  bus
);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned SET_W = $clog2(SETS);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  typedef enum logic {IDLE, AGE} state_t;

  state_t           state_q, state_d;
  cnt_t             cnt_q [SETS][WAYS];
  logic             age_pend_q;
  logic [SET_W-1:0] idx_q;
  logic             rsp_valid_q;
  logic [SET_W-1:0] rsp_set_q;
  logic [WAY_W-1:0] rsp_way_q;

  logic             accept;
  logic             hit_acc;
  logic             qry_acc;
  logic             sat_hit;
  cnt_t             hit_cur;
  logic [WAY_W-1:0] victim;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.age_busy  = (state_q == AGE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_set   = rsp_set_q;
  assign bus.rsp_way   = rsp_way_q;

  assign accept  = bus.req_valid && (state_q == IDLE);
  assign hit_acc = accept && !bus.req_op;
  assign qry_acc = accept &&  bus.req_op;
  assign hit_cur = cnt_q[bus.req_set][bus.req_way];
  // Saturates when the post-increment value is CNT_MAX, including already-full counters.
  assign sat_hit = hit_acc && (hit_cur >= (CNT_MAX - cnt_t'(1)));

  // Balanced min-tree: the left (lower-index) operand is kept unless the right is strictly smaller.
  always_comb begin
    cnt_t             tv [WAYS];
    logic [WAY_W-1:0] ti [WAYS];
    for (int unsigned w = 0; w < WAYS; w++) begin
      tv[w] = cnt_q[bus.req_set][w];
      ti[w] = WAY_W'(w);
    end
    for (int unsigned lv = 0; lv < WAY_W; lv++) begin
      for (int unsigned i = 0; i < WAYS; i += (32'd2 << lv)) begin
        if (tv[i + (32'd1 << lv)] < tv[i]) begin
          tv[i] = tv[i + (32'd1 << lv)];
          ti[i] = ti[i + (32'd1 << lv)];
        end
      end
    end
    victim = ti[0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sat_hit || age_pend_q) state_d = AGE;
      AGE:  if (idx_q == SET_W'(SETS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      age_pend_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      age_pend_q <= (state_q == AGE) ? 1'b0 : sat_hit;
      if (state_q == AGE)
        idx_q <= (idx_q == SET_W'(SETS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_set_q   <= '0;
      rsp_way_q   <= '0;
    end else begin
      rsp_valid_q <= qry_acc;
      if (qry_acc) begin
        rsp_set_q <= bus.req_set;
        rsp_way_q <= victim;
      end
    end
  end

  // Requests are only accepted in IDLE, so the sweep never races a hit or victim write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          cnt_q[s][w] <= '0;
    end else if (state_q == AGE) begin
      for (int unsigned w = 0; w < WAYS; w++)
        cnt_q[idx_q][w] <= cnt_q[idx_q][w] >> 1;
    end else if (hit_acc) begin
      cnt_q[bus.req_set][bus.req_way] <= sat_hit ? CNT_MAX : hit_cur + cnt_t'(1);
    end else if (qry_acc) begin
      cnt_q[bus.req_set][victim] <= cnt_t'(1);
    end
  end
endmodule

// File: tb/tb_rep_pol_lfu.sv
// Bench for rep_pol_lfu: directed scenarios plus random traffic against an array-based LFU model.
module tb_rep_pol_lfu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rep_pol_lfu_if #(.WAYS(4), .SETS(16)) bus ();
  rep_pol_lfu_if #(.WAYS(8), .SETS(4))  bus8 ();

  rep_pol_lfu #(.WAYS(4), .SETS(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rep_pol_lfu #(.WAYS(8), .SETS(4), .CNT_W(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int model [16][4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++)
        model[s][w] = 0;
  endfunction

  function automatic int model_victim(input int s);
    int best = 0;
    for (int w = 1; w < 4; w++)
      if (model[s][w] < model[s][best]) best = w;
    return best;
  endfunction

  task automatic do_reset();
    bus.req_valid  = 1'b0;
    bus8.req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input bit op, input int s, input int w, output bit aged);
    int n = 0;
    int v = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_set   = 4'(s);
    bus.req_way   = 2'(w);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 0, 1);
    aged = 1'b0;
    if (op) begin
      v = model_victim(s);
      model[s][v] = 1;
    end else begin
      model[s][w] = (model[s][w] + 1 > 255) ? 255 : model[s][w] + 1;
      if (model[s][w] == 255) begin
        aged = 1'b1;
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 4; b++)
            model[a][b] = model[a][b] / 2;
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rsp_valid", bus.rsp_valid, op);
    if (op) begin
      chk("rsp_way", bus.rsp_way, v);
      chk("rsp_set", bus.rsp_set, s);
    end
    chk("age_busy", bus.age_busy, aged);
  endtask

  task automatic send8(input bit op, input int s, input int w, output int rway);
    int n = 0;
    bus8.req_valid = 1'b1;
    bus8.req_op    = op;
    bus8.req_set   = 2'(s);
    bus8.req_way   = 3'(w);
    while (!bus8.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready8_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus8.req_valid = 1'b0;
    rway = int'(bus8.rsp_way);
    if (op) chk("rsp8_valid", bus8.rsp_valid, 1);
  endtask

  task automatic check_counters(input string tag);
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++)
        chk(tag, dut.cnt_q[s][w], model[s][w]);
  endtask

  initial begin
    bit aged;
    int rway;
    int cnt;
    int k;
    int pre8 [8];
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_set = '0; bus.req_way = '0;
    bus8.req_valid = 1'b0; bus8.req_op = 1'b0; bus8.req_set = '0; bus8.req_way = '0;
    do_reset();

    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.age_busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_way", bus.rsp_way, 0);
    chk("rst_rsp_set", bus.rsp_set, 0);

    // Fresh set fills ways in order, then wraps to way 0 on the all-ones tie.
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 3, 0, aged);
      chk("fill_order", bus.rsp_way, (i == 4) ? 0 : i);
    end

    for (int i = 0; i < 3; i++) send(1'b0, 5, 0, aged);
    send(1'b0, 5, 1, aged);
    for (int i = 0; i < 2; i++) send(1'b0, 5, 2, aged);
    for (int i = 0; i < 2; i++) send(1'b0, 5, 3, aged);
    send(1'b1, 5, 0, aged);
    chk("set5_victim", bus.rsp_way, 1);
    chk("set5_way1_cnt", dut.cnt_q[5][1], 1);

    for (int i = 0; i < 4; i++) send(1'b0, 7, 0, aged);
    for (int i = 0; i < 3; i++) send(1'b0, 7, 1, aged);
    send(1'b1, 7, 0, aged);
    chk("set7_tie", bus.rsp_way, 2);

    for (int i = 0; i < 1500; i++) begin
      send($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 3), aged);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    check_counters("rand_cnt");

    // Saturation sweep with a query held pending across it.
    do_reset();
    for (int i = 0; i < 5; i++) send(1'b0, 9, 1, aged);
    for (int i = 0; i < 254; i++) send(1'b0, 0, 2, aged);
    send(1'b0, 0, 2, aged);
    chk("sat_aged", aged, 1);
    bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_set = 4'd9; bus.req_way = '0;
    chk("sweep_ready", bus.req_ready, 0);
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk);
      chk("sweep_busy", bus.age_busy, 1);
      chk("sweep_ready", bus.req_ready, 0);
    end
    @(negedge clk);
    chk("post_sweep_busy", bus.age_busy, 0);
    chk("post_sweep_ready", bus.req_ready, 1);
    k = model_victim(9);
    model[9][k] = 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("held_rsp_valid", bus.rsp_valid, 1);
    chk("held_rsp_way", bus.rsp_way, k);
    chk("held_rsp_set", bus.rsp_set, 9);
    chk("aged_0_2", dut.cnt_q[0][2], 127);
    chk("aged_9_1", dut.cnt_q[9][1], 2);
    check_counters("sweep_cnt");

    // Leave a non-zero response registered, then abort a sweep with reset.
    send(1'b1, 9, 0, aged);
    chk("pre_abort_way", bus.rsp_way, 2);
    k = 0;
    aged = 1'b0;
    while (!aged && k < 300) begin
      send(1'b0, 0, 2, aged);
      k++;
    end
    if (!aged) chk("abort_trigger_timeout", 0, 1);
    repeat (8) @(negedge clk);
    chk("abort_busy_before", bus.age_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.age_busy, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_rsp_way", bus.rsp_way, 0);
    chk("abort_rsp_set", bus.rsp_set, 0);
    model_reset();
    check_counters("abort_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_busy_after", bus.age_busy, 0);
    send(1'b1, $urandom_range(0, 15), 0, aged);
    chk("abort_query", bus.rsp_way, 0);

    // Eight-way, four-set, 4-bit instance.
    do_reset();
    pre8 = '{5, 3, 7, 1, 1, 9, 2, 4};
    for (int w = 0; w < 8; w++)
      for (int i = 0; i < pre8[w]; i++) send8(1'b0, 2, w, rway);
    send8(1'b1, 2, 0, rway);
    chk("w8_victim", rway, 3);
    chk("w8_rsp_set", bus8.rsp_set, 2);
    for (int i = 0; i < 15; i++) send8(1'b0, 1, 0, rway);
    cnt = 0;
    while (bus8.age_busy && cnt < 50) begin
      cnt++;
      chk("w8_ready_low", bus8.req_ready, 0);
      @(negedge clk);
    end
    chk("w8_age_len", cnt, 4);
    chk("w8_aged_cnt", dut8.cnt_q[1][0], 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
